mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port unified memory between instruction fetch and the load/store (data) path. It sits between the fetch stage, the data-memory interface driven by `mem_en`/`rd_data_sel` decode, and the external memory. It serializes accesses, gives data accesses priority with a starvation guard for fetch, and times out unresponsive memory.

---
 rtl/mem_arbiter_if.sv | 33 +++
 rtl/mem_arbiter.sv | 69 ++++++
 tb/tb_mem_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and memory bus signals shared by the arbiter and its clients
// Ports: master = arbiter side (drives acks, read data and the mem_* request),
//        slave = requesters and memory (drive requests, mem_rdata, mem_ack).
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          bus_err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output i_ack, i_rdata, d_ack, d_rdata, bus_err, mem_req, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  i_ack, i_rdata, d_ack, d_rdata, bus_err, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and data, data-priority with fetch starvation guard and timeout
// Ports: clk, rst (async, active-high), bus (mem_arbiter_if.master: fetch i_*, data d_*, bus_err, memory mem_*).
module mem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, IFETCH, DATA} state_t;
  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [TW-1:0] to_q, to_d;
  logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          grant, ok, to_hit, fin, pick_i, pick_d;
  always_comb begin
    grant       = state_q != IDLE;
    ok          = grant && bus.mem_ack;
    // Last allowed grant cycle: to_q has counted TIMEOUT-1 silent cycles before this one
    to_hit      = grant && !bus.mem_ack && to_q == TW'(TIMEOUT - 1);
    fin         = ok || to_hit;
    pick_i      = state_q == IDLE && bus.i_req && (!bus.d_req || starve_q >= SW'(STARVE_LIMIT));
    pick_d      = state_q == IDLE && bus.d_req && !pick_i;
    state_d     = pick_i ? IFETCH : pick_d ? DATA : fin ? IDLE : state_q;
    mem_req_d   = pick_i || pick_d || (grant && !fin);
    mem_we_d    = pick_d ? bus.d_we : grant && !fin && mem_we_q;
    mem_addr_d  = pick_i ? bus.i_addr : pick_d ? bus.d_addr : mem_addr_q;
    mem_wdata_d = pick_d ? bus.d_wdata : mem_wdata_q;
    starve_d    = pick_i ? '0
                : (bus.i_req && state_q != IFETCH && starve_q != SW'(STARVE_LIMIT)) ? starve_q + SW'(1)
                : starve_q;
    to_d        = (grant && !fin) ? to_q + TW'(1) : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      to_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      to_q        <= to_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end
  assign bus.i_ack     = state_q == IFETCH && fin;
  assign bus.d_ack     = state_q == DATA && fin;
  assign bus.bus_err   = to_hit;
  assign bus.i_rdata   = (state_q == IFETCH && ok) ? bus.mem_rdata : '0;
  assign bus.d_rdata   = (state_q == DATA && ok) ? bus.mem_rdata : '0;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios for mem_arbiter with hand-computed expectations
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic auto_ack = 1'b0;
  logic man_ack = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  mem_arbiter_if #(.AW(32), .DW(32)) bus ();
  mem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4), .TIMEOUT(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // auto_ack models a zero-wait memory; man_ack lets a test place mem_ack by hand
  assign bus.mem_ack = auto_ack ? bus.mem_req : man_ack;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
    bus.mem_rdata = 0;
    tick; tick;
    @(negedge clk);
    n_cmp++; if (bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL reset mem_req: got %b expected 0", bus.mem_req); end
    n_cmp++; if (bus.mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset mem_addr: got %h expected 0", bus.mem_addr); end
    n_cmp++; if (bus.mem_we !== 1'b0 || bus.mem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset mem_we/wdata: got %b/%h expected 0/0", bus.mem_we, bus.mem_wdata); end
    n_cmp++; if ({bus.i_ack, bus.d_ack, bus.bus_err} !== 3'b000) begin n_bad++; $display("FAIL reset acks: got %b expected 000", {bus.i_ack, bus.d_ack, bus.bus_err}); end
    n_cmp++; if (bus.i_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin n_bad++; $display("FAIL reset rdata: got %h/%h expected 0/0", bus.i_rdata, bus.d_rdata); end
    tick; rst = 0;
  endtask
  task automatic test_single_fetch;
    tick; bus.i_req = 1; bus.i_addr = 32'h40; bus.mem_rdata = 32'h20080005; auto_ack = 1;
    @(negedge clk);
    n_cmp++; if (bus.mem_req !== 1'b0 || bus.i_ack !== 1'b0) begin n_bad++; $display("FAIL fetch c0: got req=%b ack=%b expected 0 0", bus.mem_req, bus.i_ack); end
    tick;
    @(negedge clk);
    n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h40 || bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL fetch c1 bus: got req=%b addr=%h we=%b expected 1 40 0", bus.mem_req, bus.mem_addr, bus.mem_we); end
    n_cmp++; if (bus.i_ack !== 1'b1 || bus.i_rdata !== 32'h20080005 || bus.d_ack !== 1'b0) begin n_bad++; $display("FAIL fetch c1 ack: got i_ack=%b rdata=%h d_ack=%b expected 1 20080005 0", bus.i_ack, bus.i_rdata, bus.d_ack); end
    tick; bus.i_req = 0;
    @(negedge clk);
    n_cmp++; if (bus.mem_req !== 1'b0 || bus.i_ack !== 1'b0 || bus.i_rdata !== 32'h0) begin n_bad++; $display("FAIL fetch c2: got req=%b ack=%b rdata=%h expected 0 0 0", bus.mem_req, bus.i_ack, bus.i_rdata); end
  endtask
  task automatic test_simultaneous;
    tick; bus.i_req = 1; bus.i_addr = 32'h80; bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEADBEEF;
    tick;
    @(negedge clk);
    n_cmp++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h100 || bus.mem_wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL simul c1 bus: got we=%b addr=%h wdata=%h expected 1 100 deadbeef", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    n_cmp++; if (bus.d_ack !== 1'b1 || bus.i_ack !== 1'b0) begin n_bad++; $display("FAIL simul c1 ack: got d=%b i=%b expected 1 0", bus.d_ack, bus.i_ack); end
    tick; bus.d_req = 0;
    @(negedge clk);
    n_cmp++; if (bus.mem_req !== 1'b0 || dut.starve_q !== 3'd2) begin n_bad++; $display("FAIL simul c2: got req=%b starve=%0d expected 0 2", bus.mem_req, dut.starve_q); end
    tick;
    @(negedge clk);
    n_cmp++; if (bus.i_ack !== 1'b1 || bus.mem_addr !== 32'h80 || bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL simul c3 fetch: got ack=%b addr=%h we=%b expected 1 80 0", bus.i_ack, bus.mem_addr, bus.mem_we); end
    n_cmp++; if (dut.starve_q !== 3'd0) begin n_bad++; $display("FAIL simul starve clear: got %0d expected 0", dut.starve_q); end
    tick; bus.i_req = 0;
  endtask
  task automatic test_starvation;
    tick; bus.i_req = 1; bus.i_addr = 32'hC0; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200; bus.mem_rdata = 32'h11112222;
    for (int c = 1; c <= 5; c++) begin
      tick;
      @(negedge clk);
      n_cmp++; if (bus.d_ack !== (c == 1 || c == 3) || bus.i_ack !== (c == 5)) begin n_bad++; $display("FAIL starve c%0d: got d_ack=%b i_ack=%b expected %b %b", c, bus.d_ack, bus.i_ack, c == 1 || c == 3, c == 5); end
      if (c == 1) begin
        n_cmp++; if (bus.d_rdata !== 32'h11112222 || bus.mem_addr !== 32'h200) begin n_bad++; $display("FAIL starve load: got rdata=%h addr=%h expected 11112222 200", bus.d_rdata, bus.mem_addr); end
      end
      if (c == 5) begin
        n_cmp++; if (bus.mem_addr !== 32'hC0 || bus.i_rdata !== 32'h11112222) begin n_bad++; $display("FAIL starve fetch: got addr=%h rdata=%h expected c0 11112222", bus.mem_addr, bus.i_rdata); end
      end
    end
    tick; bus.i_req = 0; bus.d_req = 0;
  endtask
  task automatic test_timeout;
    auto_ack = 0; man_ack = 0; bus.mem_rdata = 32'hAAAA5555;
    tick; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h300;
    for (int c = 1; c <= 8; c++) begin
      tick;
      @(negedge clk);
      n_cmp++; if (bus.mem_req !== 1'b1 || bus.d_ack !== (c == 8) || bus.bus_err !== (c == 8)) begin n_bad++; $display("FAIL timeout c%0d: got req=%b ack=%b err=%b expected 1 %b %b", c, bus.mem_req, bus.d_ack, bus.bus_err, c == 8, c == 8); end
    end
    n_cmp++; if (bus.d_rdata !== 32'h0) begin n_bad++; $display("FAIL timeout rdata: got %h expected 0", bus.d_rdata); end
    tick; bus.d_req = 0;
    @(negedge clk);
    n_cmp++; if (bus.mem_req !== 1'b0 || bus.bus_err !== 1'b0) begin n_bad++; $display("FAIL timeout c9: got req=%b err=%b expected 0 0", bus.mem_req, bus.bus_err); end
    tick; bus.d_req = 1;
    for (int c = 1; c <= 8; c++) begin
      tick;
      man_ack = c == 8;
      @(negedge clk);
      n_cmp++; if (bus.d_ack !== (c == 8) || bus.bus_err !== 1'b0) begin n_bad++; $display("FAIL late ack c%0d: got ack=%b err=%b expected %b 0", c, bus.d_ack, bus.bus_err, c == 8); end
    end
    n_cmp++; if (bus.d_rdata !== 32'hAAAA5555) begin n_bad++; $display("FAIL late ack rdata: got %h expected aaaa5555", bus.d_rdata); end
    tick; bus.d_req = 0; man_ack = 0;
    @(negedge clk);
    n_cmp++; if (bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL late ack c9: got req=%b expected 0", bus.mem_req); end
  endtask
  task automatic test_reset_mid;
    tick; bus.i_req = 1; bus.i_addr = 32'h500;
    tick;
    @(negedge clk);
    n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h500) begin n_bad++; $display("FAIL midrst c1: got req=%b addr=%h expected 1 500", bus.mem_req, bus.mem_addr); end
    tick; man_ack = 1;
    #1 rst = 1;
    #1;
    n_cmp++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0) begin n_bad++; $display("FAIL midrst bus: got req=%b addr=%h expected 0 0", bus.mem_req, bus.mem_addr); end
    n_cmp++; if (bus.i_ack !== 1'b0 || bus.d_ack !== 1'b0 || bus.i_rdata !== 32'h0) begin n_bad++; $display("FAIL midrst ack: got i=%b d=%b rdata=%h expected 0 0 0", bus.i_ack, bus.d_ack, bus.i_rdata); end
    n_cmp++; if (dut.starve_q !== 3'd0 || dut.to_q !== 4'd0) begin n_bad++; $display("FAIL midrst counters: got starve=%0d to=%0d expected 0 0", dut.starve_q, dut.to_q); end
    bus.i_req = 0; man_ack = 0;
    tick; rst = 0;
    tick; bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h600; bus.d_wdata = 32'h12345678; auto_ack = 1;
    tick;
    @(negedge clk);
    n_cmp++; if (bus.d_ack !== 1'b1 || bus.mem_addr !== 32'h600 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'h12345678) begin n_bad++; $display("FAIL post-rst store: got ack=%b addr=%h we=%b wdata=%h expected 1 600 1 12345678", bus.d_ack, bus.mem_addr, bus.mem_we, bus.mem_wdata); end
    tick; bus.d_req = 0; auto_ack = 0;
  endtask
  task automatic test_stray_ack;
    tick; man_ack = 1;
    @(negedge clk);
    n_cmp++; if ({bus.i_ack, bus.d_ack, bus.bus_err} !== 3'b000) begin n_bad++; $display("FAIL stray acks: got %b expected 000", {bus.i_ack, bus.d_ack, bus.bus_err}); end
    tick; man_ack = 0;
    @(negedge clk);
    n_cmp++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h600 || dut.state_q !== 2'd0) begin n_bad++; $display("FAIL stray state: got req=%b addr=%h state=%0d expected 0 600 0", bus.mem_req, bus.mem_addr, dut.state_q); end
  endtask
  initial begin
    test_reset;
    test_single_fetch;
    test_simultaneous;
    test_starvation;
    test_timeout;
    test_reset_mid;
    test_stray_ack;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
